// File: rtl/stream_slip_encoder_if.sv
// Byte stream bundle: framed input (data + eof) and encoded output, each with valid/ready.
// The producer of din and consumer of dout uses master; the encoder uses slave.
interface stream_slip_encoder_if;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] din_data;
    logic       din_eof;
    logic       dout_valid;
    logic       dout_ready;
    logic [7:0] dout_data;

    modport master (
        output din_valid, din_data, din_eof, dout_ready,
        input  din_ready, dout_valid, dout_data
    );

    modport slave (
        input  din_valid, din_data, din_eof, dout_ready,
        output din_ready, dout_valid, dout_data
    );
endinterface

// File: rtl/stream_slip_encoder.sv
// SLIP (RFC 1055) framer: eof-delimited bytes in, escaped END-delimited bytes out; 1-cycle registered latency.
// A stalled output (dout_valid && !dout_ready) freezes state, pend and the output byte; din_ready drops with it.
module stream_slip_encoder #(
    parameter logic [7:0] EndChar    = 8'hC0,
    parameter logic [7:0] EscChar    = 8'hDB,
    parameter logic [7:0] EscEnd     = 8'hDC,
    parameter logic [7:0] EscEsc     = 8'hDD,
    parameter bit         LeadingEnd = 1'b1,
    parameter int         CountBits  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_slip_encoder_if.slave bus,
    output logic                 frame_done,
    output logic [CountBits-1:0] frame_count
);

    typedef enum logic [1:0] {ST_SOF, ST_DATA, ST_ESC, ST_EOF} state_t;

    localparam state_t StartState = LeadingEnd ? ST_SOF : ST_DATA;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pend;
    logic       pend_eof;

    logic       load_ok;
    logic       accept;
    logic       din_is_end;
    logic       din_is_esc;
    logic       load;
    logic [7:0] load_data;
    logic       pend_load;
    logic [7:0] pend_data;
    logic       done;

    assign load_ok       = !bus.dout_valid || bus.dout_ready;
    assign bus.din_ready = (state == ST_DATA) && load_ok;
    assign accept        = bus.din_valid && bus.din_ready;
    assign din_is_end    = (bus.din_data == EndChar);
    assign din_is_esc    = (bus.din_data == EscChar);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StartState;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_SOF: begin
                // The leading END is only sent once a frame is actually waiting.
                if (bus.din_valid && load_ok) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (din_is_end || din_is_esc) begin
                        state_nxt = ST_ESC;
                    end else if (bus.din_eof) begin
                        state_nxt = ST_EOF;
                    end
                end
            end
            ST_ESC: begin
                if (load_ok) begin
                    state_nxt = pend_eof ? ST_EOF : ST_DATA;
                end
            end
            ST_EOF: begin
                if (load_ok) begin
                    state_nxt = StartState;
                end
            end
            default: state_nxt = StartState;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        load_data = 8'h00;
        pend_load = 1'b0;
        pend_data = pend;
        done      = 1'b0;
        case (state)
            ST_SOF: begin
                if (bus.din_valid && load_ok) begin
                    load      = 1'b1;
                    load_data = EndChar;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    load = 1'b1;
                    if (din_is_end || din_is_esc) begin
                        load_data = EscChar;
                        pend_load = 1'b1;
                        pend_data = din_is_end ? EscEnd : EscEsc;
                    end else begin
                        load_data = bus.din_data;
                    end
                end
            end
            ST_ESC: begin
                if (load_ok) begin
                    load      = 1'b1;
                    load_data = pend;
                end
            end
            ST_EOF: begin
                if (load_ok) begin
                    load      = 1'b1;
                    load_data = EndChar;
                    done      = 1'b1;
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout_valid <= 1'b0;
            bus.dout_data  <= 8'h00;
            pend           <= 8'h00;
            pend_eof       <= 1'b0;
            frame_done     <= 1'b0;
            frame_count    <= '0;
        end else begin
            frame_done <= done;
            if (load) begin
                bus.dout_valid <= 1'b1;
                bus.dout_data  <= load_data;
            end else if (load_ok) begin
                bus.dout_valid <= 1'b0;
            end
            // The eof of an escaped byte travels with the second half of the pair.
            if (pend_load) begin
                pend     <= pend_data;
                pend_eof <= bus.din_eof;
            end
            if (done) begin
                frame_count <= frame_count + {{(CountBits-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_stream_slip_encoder.sv
// Bench for stream_slip_encoder: fixed frame table, hand-written corner sequences and randomized frames vs a SLIP model.
module tb_stream_slip_encoder;

    logic        clk;
    logic        rst;
    logic        fd_a;
    logic        fd_b;
    logic [15:0] fc_a;
    logic [1:0]  fc_b;

    stream_slip_encoder_if ia ();
    stream_slip_encoder_if ib ();

    stream_slip_encoder u_a (
        .clk         (clk),
        .rst         (rst),
        .bus         (ia.slave),
        .frame_done  (fd_a),
        .frame_count (fc_a)
    );

    stream_slip_encoder #(
        .LeadingEnd (1'b0),
        .CountBits  (2)
    ) u_b (
        .clk         (clk),
        .rst         (rst),
        .bus         (ib.slave),
        .frame_done  (fd_b),
        .frame_count (fc_b)
    );

    typedef struct {
        logic [3:0][7:0] din;   // byte 0 in the low lane
        int              n;
        logic [7:0][7:0] exp;
        int              m;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_a = 0;
    int          exp_done = 0;
    int          exp_frames = 0;
    bit          prev_stall = 0;
    bit          prev_esc = 0;
    bit          rand_rdy = 0;
    logic [7:0]  prev_data;
    logic [7:0]  qa[$];
    int          qcyc[$];
    logic [7:0]  qb[$];
    logic [7:0]  expq[$];
    logic [7:0]  fr[$];
    vec_t        vecs[6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // SLIP framing as RFC 1055 states it, with the optional leading END.
    function automatic void model_frame(input logic [7:0] f[$]);
        expq.push_back(8'hC0);
        foreach (f[i]) begin
            if (f[i] == 8'hC0) begin
                expq.push_back(8'hDB);
                expq.push_back(8'hDC);
            end else if (f[i] == 8'hDB) begin
                expq.push_back(8'hDB);
                expq.push_back(8'hDD);
            end else begin
                expq.push_back(f[i]);
            end
        end
        expq.push_back(8'hC0);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
            prev_esc   = 0;
        end else begin
            if (prev_stall)
                chk("hold_when_stalled", {23'd0, ia.dout_valid, ia.dout_data}, {23'd0, 1'b1, prev_data});
            if (prev_esc)
                chk("din_ready_after_escape", {31'd0, ia.din_ready}, 32'd0);
            if (fd_a) begin
                done_a++;
                chk("frame_done_on_end", {23'd0, ia.dout_valid, ia.dout_data}, {23'd0, 1'b1, 8'hC0});
            end
            if (ia.dout_valid && ia.dout_ready) begin
                qa.push_back(ia.dout_data);
                qcyc.push_back(cyc);
            end
            prev_stall = ia.dout_valid && !ia.dout_ready;
            prev_data  = ia.dout_data;
            prev_esc   = ia.din_valid && ia.din_ready && (ia.din_data == 8'hC0 || ia.din_data == 8'hDB);
            if (ib.dout_valid && ib.dout_ready)
                qb.push_back(ib.dout_data);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy)
                ia.dout_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Called and returns at posedge+1; the byte has been accepted on the last posedge.
    task automatic send_byte(input int which, input logic [7:0] d, input logic e);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        if (which == 0) begin
            ia.din_valid = 1'b1; ia.din_data = d; ia.din_eof = e;
        end else begin
            ib.din_valid = 1'b1; ib.din_data = d; ib.din_eof = e;
        end
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = (which == 0) ? (ia.din_valid && ia.din_ready) : (ib.din_valid && ib.din_ready);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept, want accept within 200 cycles");
        end
        if (which == 0) ia.din_valid = 1'b0;
        else            ib.din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bit idle;
        n    = 0;
        idle = 0;
        while (!idle && n < 1000) begin
            @(negedge clk);
            idle = !ia.dout_valid;
            n++;
        end
        @(posedge clk);
        #1;
        if (!idle) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got dout_valid stuck, want idle within 1000 cycles");
        end
    endtask

    task automatic compare_stream(input string nm);
        chk({nm, "_len"}, qa.size(), expq.size());
        for (int i = 0; i < qa.size() && i < expq.size(); i++)
            chk({nm, "_byte"}, qa[i], expq[i]);
    endtask

    initial begin
        vecs[0] = '{din: 32'h0003_0201, n: 3, exp: 64'h0000_00C0_0302_01C0, m: 5};
        vecs[1] = '{din: 32'h007E_DBC0, n: 3, exp: 64'h00C0_7EDD_DBDC_DBC0, m: 7};
        vecs[2] = '{din: 32'h0000_C041, n: 2, exp: 64'h0000_00C0_DCDB_41C0, m: 5};
        vecs[3] = '{din: 32'h0000_00DD, n: 1, exp: 64'h0000_0000_00C0_DDC0, m: 3};
        vecs[4] = '{din: 32'h0000_00DB, n: 1, exp: 64'h0000_0000_C0DD_DBC0, m: 4};
        vecs[5] = '{din: 32'h0000_C0C0, n: 2, exp: 64'h0000_C0DC_DBDC_DBC0, m: 6};

        rst = 1'b1;
        ia.din_valid = 1'b0; ia.din_data = 8'h00; ia.din_eof = 1'b0; ia.dout_ready = 1'b1;
        ib.din_valid = 1'b0; ib.din_data = 8'h00; ib.din_eof = 1'b0; ib.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_dout_valid", {31'd0, ia.dout_valid}, 32'd0);
        chk("rst_dout_data", {24'd0, ia.dout_data}, 32'd0);
        chk("rst_frame_done", {31'd0, fd_a}, 32'd0);
        chk("rst_frame_count", {16'd0, fc_a}, 32'd0);
        chk("rst_din_ready_sof", {31'd0, ia.din_ready}, 32'd0);
        chk("rst_din_ready_data", {31'd0, ib.din_ready}, 32'd1);
        @(posedge clk);
        #1;

        // No leading END, 2-bit counter: wraps after three frames.
        for (int k = 0; k < 5; k++) begin
            send_byte(1, 8'h55, 1'b1);
            @(posedge clk);
            #1;
            chk("count_wrap", {30'd0, fc_b}, (k + 1) % 4);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("noleading_len", qb.size(), 10);
        for (int i = 0; i < qb.size() && i < 10; i++)
            chk("noleading_byte", qb[i], (i % 2 == 1) ? 8'hC0 : 8'h55);

        for (int v = 0; v < 6; v++) begin
            qa.delete();
            qcyc.delete();
            for (int i = 0; i < vecs[v].n; i++)
                send_byte(0, vecs[v].din[i], i == vecs[v].n - 1);
            drain();
            exp_frames++;
            exp_done++;
            chk("vec_len", qa.size(), vecs[v].m);
            for (int j = 0; j < qa.size() && j < vecs[v].m; j++)
                chk("vec_byte", qa[j], vecs[v].exp[j]);
            if (qcyc.size() == vecs[v].m)
                chk("vec_back_to_back_out", qcyc[vecs[v].m-1] - qcyc[0], vecs[v].m - 1);
            chk("vec_frame_count", fc_a, exp_frames[15:0]);
            chk("vec_frame_done", done_a, exp_done);
        end

        // Two frames with no gap: the second leading END follows the first trailing END.
        qa.delete(); qcyc.delete(); expq.delete();
        fr.delete(); fr.push_back(8'h11); model_frame(fr);
        fr.delete(); fr.push_back(8'h22); model_frame(fr);
        send_byte(0, 8'h11, 1'b1);
        send_byte(0, 8'h22, 1'b1);
        drain();
        exp_frames += 2;
        exp_done += 2;
        compare_stream("b2b");
        if (qcyc.size() == 6)
            chk("b2b_span", qcyc[5] - qcyc[0], 5);
        chk("b2b_frame_count", fc_a, exp_frames[15:0]);

        qa.delete(); expq.delete();
        rand_rdy = 1;
        for (int f = 0; f < 200; f++) begin
            int len;
            len = $urandom_range(1, 6);
            fr.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 5))
                    0:       fr.push_back(8'hC0);
                    1:       fr.push_back(8'hDB);
                    2:       fr.push_back(8'hDC);
                    3:       fr.push_back(8'hDD);
                    default: fr.push_back(8'($urandom));
                endcase
            end
            model_frame(fr);
            for (int i = 0; i < len; i++)
                send_byte(0, fr[i], i == len - 1);
            repeat ($urandom_range(0, 2)) begin
                ia.din_data = 8'($urandom);
                ia.din_eof  = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 0;
        ia.dout_ready = 1'b1;
        drain();
        exp_frames += 200;
        exp_done += 200;
        compare_stream("random");
        chk("random_frame_count", fc_a, exp_frames[15:0]);
        chk("random_frame_done", done_a, exp_done);

        // Reset while the byte after the leading END sits stalled on the output.
        qa.delete();
        ia.dout_ready = 1'b1;
        send_byte(0, 8'h01, 1'b0);
        ia.dout_ready = 1'b0;
        @(negedge clk);
        chk("stall_before_reset", {23'd0, ia.dout_valid, ia.dout_data}, {23'd0, 1'b1, 8'h01});
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dout_valid", {31'd0, ia.dout_valid}, 32'd0);
        chk("async_rst_dout_data", {24'd0, ia.dout_data}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ia.dout_ready = 1'b1;
        exp_done = done_a;
        qa.delete(); expq.delete();
        fr.delete(); fr.push_back(8'h02); model_frame(fr);
        send_byte(0, 8'h02, 1'b1);
        chk("after_rst_count_pending", fc_a, 32'd0);
        drain();
        compare_stream("after_rst");
        chk("after_rst_count", fc_a, 32'd1);
        chk("after_rst_done", done_a, exp_done + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_slip_encoder.md
Name: stream_slip_encoder

Overview:
- Downstream consumer of the DMA memory-to-stream output (8-bit data + eof).
- Converts eof-delimited frames into a SLIP-encoded byte stream (RFC 1055) for a byte-serial link such as UART or trace pins.
- Escapes in-band END/ESC bytes and marks each frame boundary with END.
- One output byte per cycle, registered output.

Parameters:
- EndChar, 8'hC0, frame delimiter byte.
- EscChar, 8'hDB, escape prefix byte.
- EscEnd, 8'hDC, byte sent after EscChar in place of an EndChar data byte.
- EscEsc, 8'hDD, byte sent after EscChar in place of an EscChar data byte.
- LeadingEnd, 1, 1 = also emit EndChar before the first byte of each frame.
- CountBits, 16, width of the frame counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  input byte valid.
- din_ready  out  1  input byte accepted when din_valid && din_ready.
- din_data  in  8  input byte.
- din_eof  in  1  marks last byte of the frame.
- dout_valid  out  1  encoded byte valid.
- dout_ready  in  1  downstream ready.
- dout_data  out  8  encoded byte.
- frame_done  out  1  one-cycle pulse when a frame's trailing EndChar is loaded to the output.
- frame_count  out  CountBits  number of completed frames, wraps modulo 2^CountBits.

Behaviour:
- Reset is asynchronous.
  - On reset: dout_valid=0, dout_data=0, frame_done=0, frame_count=0, pend=0, pend_eof=0.
  - State resets to SOF if LeadingEnd=1, otherwise DATA.
- Output register:
  - load_ok = !dout_valid || dout_ready.
  - A load sets dout_valid=1 and dout_data=<byte>.
  - If load_ok and nothing is loaded, dout_valid goes to 0.
  - While dout_valid && !dout_ready, dout_data holds stable.
- din_ready = (state==DATA) && load_ok. This is combinational from dout_ready; there is no other combinational input-to-output path.
- State SOF:
  - When din_valid && load_ok: load EndChar and go to DATA.
  - The input byte is not consumed.
  - No output is produced while din_valid=0, so there are no idle fill bytes.
- State DATA, on input accept:
  - din_data==EndChar: load EscChar, pend=EscEnd, pend_eof=din_eof, go to ESC.
  - din_data==EscChar: load EscChar, pend=EscEsc, pend_eof=din_eof, go to ESC.
  - Any other byte: load din_data. If din_eof, go to EOF; otherwise stay in DATA.
- State ESC: when load_ok, load pend. Go to EOF if pend_eof, otherwise DATA.
- State EOF:
  - When load_ok: load EndChar, pulse frame_done, increment frame_count.
  - Next state is SOF if LeadingEnd=1, otherwise DATA.
- Latency and throughput:
  - A byte accepted in cycle N appears on dout in cycle N+1.
  - Sustained output is 1 byte/cycle with dout_ready=1.
  - Input rate is 1 byte/cycle for unescaped bytes, and 1 byte per 2 cycles for escaped bytes.
- Boundary conditions:
  - Single-byte frame with eof: SOF → DATA → EOF yields 3 output bytes (2 with LeadingEnd=0).
  - Escaped byte carrying eof: the escape pair is emitted before the trailing EndChar.
  - Back-to-back frames: the new frame's leading EndChar directly follows the previous trailing EndChar.
  - frame_count wraps from all-ones to 0 with no flag.
  - Backpressure in any state freezes state, pend and the output register.
  - Reset mid-frame discards the partial frame and the output byte. The next frame starts clean; no trailing EndChar is emitted for the aborted frame.
  - din_data/din_eof are only sampled on accept; changes while din_ready=0 are ignored.

Test Plan:
- LeadingEnd=1, frame {01,02,03 eof}, dout_ready=1 → dout C0,01,02,03,C0 on 5 consecutive cycles; frame_done pulses once; frame_count=1.
- Frame {C0,DB,7E eof} → C0,DB,DC,DB,DD,7E,C0; din_ready low on the cycle after each escaped accept.
- Frame {41, C0 eof} → C0,41,DB,DC,C0; frame_done fires on the last C0 load, not on the DC load.
- Random dout_ready (50%) over 200 random frames, reference model compares the byte stream → exact match; dout_data stable whenever dout_valid && !dout_ready.
- LeadingEnd=0, CountBits=2, five single-byte frames {55 eof} → 55,C0 ×5; frame_count sequence 1,2,3,0,1.
- Assert rst mid-frame after 01 is emitted with dout_ready=0 → dout_valid=0 immediately (async). Next frame {02 eof} yields C0,02,C0; frame_count=0 until it completes.
